// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared definitions for the register-file writeback scheduler.
//
// Contents:
//   DATA_W_DEF / ADDR_W_DEF : default data and register-address widths
//   REG_ZERO                : architectural zero register index (never written)
//   REQ_ALU / REQ_MEM       : requester indices into the arbiter request/grant vectors
//   rr_ptr_e                : round-robin preference state of the writeback arbiter
package regfile_wb_scheduler_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam int REG_ZERO = 0;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    // Which requester wins when both ask in the same cycle.
    typedef enum logic {
        PREF_ALU = 1'b0,
        PREF_MEM = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter for the writeback port.
//
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   i_req    : request vector, bit REQ_ALU = ALU, bit REQ_MEM = load path
//   o_gnt    : combinational one-hot (or zero) grant; a bit is only set
//              when the matching request is set
//   o_ptr    : current preference state, exported for observation
//
// Handshake: a requester transfers on any cycle where its request and its
// grant are both high. The preference flips to the other requester after
// every transfer and holds when nothing is granted.
module rr_arbiter2
    import regfile_wb_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output rr_ptr_e    o_ptr
);

    rr_ptr_e r_ptr;
    rr_ptr_e w_ptr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= PREF_ALU;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    always_comb begin
        o_gnt     = 2'b00;
        w_ptr_nxt = r_ptr;

        if (i_req[REQ_ALU] && i_req[REQ_MEM]) begin
            if (r_ptr == PREF_ALU) begin
                o_gnt[REQ_ALU] = 1'b1;
            end else begin
                o_gnt[REQ_MEM] = 1'b1;
            end
        end else if (i_req[REQ_ALU]) begin
            o_gnt[REQ_ALU] = 1'b1;
        end else if (i_req[REQ_MEM]) begin
            o_gnt[REQ_MEM] = 1'b1;
        end

        // Every grant is a transfer, so the winner yields priority next time.
        if (o_gnt[REQ_ALU]) begin
            w_ptr_nxt = PREF_MEM;
        end else if (o_gnt[REQ_MEM]) begin
            w_ptr_nxt = PREF_ALU;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler between the execute/memory stages and the single
// register-file write port.
//
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   alloc_valid, alloc_rd           : decode allocates a destination register
//   alloc_stall                     : allocation blocked, destination still pending
//   rs_addr, rt_addr                : decode source register queries
//   rs_busy, rt_busy                : source register has a write in flight
//   alu_valid/ready/rd/data         : ALU writeback request channel
//   mem_valid/ready/rd/data         : load writeback request channel
//   rf_we, rf_waddr, rf_wdata       : registered register-file write port
//   dbg_rr_ptr                      : arbiter preference state (observation only)
//
// Handshake: a channel transfers on a cycle where valid && ready. ready is
// combinational, only ever asserted alongside valid, and the requester holds
// rd/data stable while valid && !ready.
//
// A transfer in cycle N appears on the write port in cycle N+1. Transfers to
// register 0 are accepted but produce no write enable. The pending bit of the
// written register clears at the edge that ends the write cycle, so busy drops
// in the same cycle the register file shows the new value.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_rd,
    output logic              alloc_stall,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output rr_ptr_e           dbg_rr_ptr
);

    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [1:0]        w_gnt;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_alloc_set;
    logic [NREGS-1:0]  w_pending_nxt;

    logic [NREGS-1:0]  r_pending;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req ({mem_valid, alu_valid}),
        .o_gnt (w_gnt),
        .o_ptr (dbg_rr_ptr)
    );

    assign alu_ready = w_gnt[REQ_ALU];
    assign mem_ready = w_gnt[REQ_MEM];

    // Grants are only issued against valid requests, so any grant is a transfer.
    assign w_xfer     = |w_gnt;
    assign w_sel_rd   = w_gnt[REQ_MEM] ? mem_rd   : alu_rd;
    assign w_sel_data = w_gnt[REQ_MEM] ? mem_data : alu_data;

    // ------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_xfer && (w_sel_rd != ZERO_ADDR);
            if (w_xfer) begin
                r_rf_waddr <= w_sel_rd;
                r_rf_wdata <= w_sel_data;
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

    // ------------------------------------------------------------------
    // Pending scoreboard
    // ------------------------------------------------------------------
    assign alloc_stall = alloc_valid && r_pending[alloc_rd] && (alloc_rd != ZERO_ADDR);
    assign w_alloc_set = alloc_valid && !alloc_stall && (alloc_rd != ZERO_ADDR);

    always_comb begin
        w_pending_nxt = r_pending;
        if (r_rf_we) begin
            w_pending_nxt[r_rf_waddr] = 1'b0;
        end
        // Applied after the clear so a same-register allocation keeps the bit set.
        if (w_alloc_set) begin
            w_pending_nxt[alloc_rd] = 1'b1;
        end
        w_pending_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign rs_busy = (rs_addr != ZERO_ADDR) && r_pending[rs_addr];
    assign rt_busy = (rt_addr != ZERO_ADDR) && r_pending[rt_addr];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler. Inputs change on the falling
// edge; combinational outputs are sampled 1 ns after that, registered outputs
// 1 ns after the rising edge. Every accepted non-zero writeback pushes its
// expected {addr, data} into exp_q; a monitor pops and compares on each
// falling edge where rf_we is high.
module tb_regfile_wb_scheduler;
    import regfile_wb_scheduler_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int W      = ADDR_W + DATA_W;

    logic              clk;
    logic              rst;
    logic              alloc_valid;
    logic [ADDR_W-1:0] alloc_rd;
    logic              alloc_stall;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rs_busy;
    logic              rt_busy;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    rr_ptr_e           dbg_rr_ptr;

    logic [W-1:0] exp_q[$];
    int           n_checks;
    int           n_fail;
    bit           m_pref_alu;   // model of which side wins a tie

    regfile_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .alloc_stall (alloc_stall),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .dbg_rr_ptr  (dbg_rr_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && rf_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got write addr=%0d data=%h, required no write",
                         rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL wb_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             rf_waddr, rf_wdata, e[W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        alloc_valid = 1'b0;
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        alloc_rd = '0; rs_addr = '0; rt_addr = '0;
        alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0;
        m_pref_alu = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_wport: got we=%b addr=%0d data=%h, required all 0", rf_we, rf_waddr, rf_wdata);
        end
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got alu=%b mem=%b, required 0 0", alu_ready, mem_ready);
        end
    endtask

    task automatic test_alloc();
        @(negedge clk);
        alloc_valid = 1'b1; alloc_rd = 5'd5;
        #1;
        n_checks++;
        if (alloc_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alloc_first_stall: got %b, required 0", alloc_stall);
        end
        @(negedge clk);
        alloc_valid = 1'b0; rs_addr = 5'd5;
        #1;
        n_checks++;
        if (rs_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL alloc_busy: got rs_busy=%b, required 1", rs_busy);
        end
        alloc_valid = 1'b1; alloc_rd = 5'd5;
        #1;
        n_checks++;
        if (alloc_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL alloc_realloc_stall: got %b, required 1", alloc_stall);
        end
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL alloc_no_we: got rf_we=%b, required 0", rf_we);
        end
        @(negedge clk);
        alloc_valid = 1'b0;
    endtask

    task automatic test_alu_write();
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
        #1;
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL alu_grant: got alu=%b mem=%b, required 1 0", alu_ready, mem_ready);
        end
        exp_q.push_back({5'd5, 32'h0000_00AA});
        m_pref_alu = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h0000_00AA}) begin
            n_fail++;
            $display("FAIL alu_wport: got we=%b addr=%0d data=%h, required 1 5 000000aa", rf_we, rf_waddr, rf_wdata);
        end
        n_checks++;
        if (rs_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_busy_n1: got rs_busy=%b, required 1", rs_busy);
        end
        @(negedge clk);
        alu_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (rs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_busy_n2: got rs_busy=%b, required 0", rs_busy);
        end
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'h0000_00AA}) begin
            n_fail++;
            $display("FAIL alu_hold: got we=%b addr=%0d data=%h, required 0 5 000000aa", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_rd_zero();
        @(negedge clk);
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL zero_grant: got alu=%b mem=%b, required 0 1", alu_ready, mem_ready);
        end
        m_pref_alu = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_no_we: got rf_we=%b, required 0", rf_we);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        n_checks++;
        if (alloc_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_alloc_stall: got %b, required 0", alloc_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({alloc_stall, rs_busy, rt_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_alloc_busy: got stall=%b rs=%b rt=%b, required 0 0 0", alloc_stall, rs_busy, rt_busy);
        end
        @(negedge clk);
        alloc_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] a_d;
        logic [DATA_W-1:0] m_d;
        a_d = $urandom;
        m_d = $urandom;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            alu_valid = 1'b1; alu_rd = 5'd3; alu_data = a_d;
            mem_valid = 1'b1; mem_rd = 5'd4; mem_data = m_d;
            #1;
            n_checks++;
            if ({alu_ready, mem_ready} !== {m_pref_alu, !m_pref_alu}) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got alu=%b mem=%b, required %b %b",
                         i, alu_ready, mem_ready, m_pref_alu, !m_pref_alu);
            end
            if (m_pref_alu) begin
                exp_q.push_back({5'd3, a_d});
                a_d = $urandom;
            end else begin
                exp_q.push_back({5'd4, m_d});
                m_d = $urandom;
            end
            m_pref_alu = !m_pref_alu;
            @(posedge clk); #1;
            n_checks++;
            if (rf_we !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_we_%0d: got rf_we=%b, required 1", i, rf_we);
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_same_edge();
        logic [DATA_W-1:0] d;
        // Write to a register that is not pending, and allocate it on the
        // edge that commits that write: the new pending bit must survive.
        d = $urandom;
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = d;
        #1;
        n_checks++;
        if (alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL same_grant: got alu_ready=%b, required 1", alu_ready);
        end
        exp_q.push_back({5'd7, d});
        m_pref_alu = 1'b0;
        @(negedge clk);
        alu_valid = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd7; rt_addr = 5'd7;
        #1;
        n_checks++;
        if ({rf_we, alloc_stall} !== 2'b10) begin
            n_fail++;
            $display("FAIL same_setup: got we=%b stall=%b, required 1 0", rf_we, alloc_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rt_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL same_set_wins: got rt_busy=%b, required 1", rt_busy);
        end
        @(negedge clk);
        alloc_valid = 1'b0;
        // Now pending: a re-allocation during the committing write is stalled.
        d = $urandom;
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = d;
        exp_q.push_back({5'd7, d});
        m_pref_alu = 1'b0;
        @(negedge clk);
        alu_valid = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        #1;
        n_checks++;
        if ({rf_we, alloc_stall} !== 2'b11) begin
            n_fail++;
            $display("FAIL same_stall: got we=%b stall=%b, required 1 1", rf_we, alloc_stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({rt_busy, alloc_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL same_cleared: got rt_busy=%b stall=%b, required 0 0", rt_busy, alloc_stall);
        end
        @(negedge clk);
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] d;
        @(negedge clk);
        alloc_valid = 1'b1; alloc_rd = 5'd2;
        @(negedge clk);
        alloc_rd = 5'd9;
        @(negedge clk);
        alloc_valid = 1'b0; rs_addr = 5'd2; rt_addr = 5'd9;
        #1;
        n_checks++;
        if ({rs_busy, rt_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL rmid_pending: got rs=%b rt=%b, required 1 1", rs_busy, rt_busy);
        end
        d = $urandom_range(32'h0FFF_FFFF, 32'h0000_0001);
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = d;
        exp_q.push_back({5'd2, d});
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        n_checks++;
        if (rf_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_we_before: got rf_we=%b, required 1", rf_we);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== '0) begin
            n_fail++;
            $display("FAIL rmid_wport: got we=%b addr=%0d data=%h, required all 0", rf_we, rf_waddr, rf_wdata);
        end
        n_checks++;
        if ({rs_busy, rt_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL rmid_busy: got rs=%b rt=%b, required 0 0", rs_busy, rt_busy);
        end
        m_pref_alu = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        d = $urandom;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = d;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = $urandom;
        #1;
        n_checks++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rmid_first_grant: got alu=%b mem=%b, required 1 0", alu_ready, mem_ready);
        end
        exp_q.push_back({5'd3, d});
        m_pref_alu = 1'b0;
        @(negedge clk);
        drive_idle();
        repeat (2) @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alloc();
        test_alu_write();
        test_rd_zero();
        test_back_to_back();
        test_same_edge();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wb_missing: got %0d writes never observed, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
